// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback stage.
// Holds width defaults, result-source codes and FSM encoding.
package wb_pkg;

  localparam int WB_DATA_W = 16;
  localparam int WB_ADDR_W = 3;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [1:0] WB_SEL_IMM  = 2'b10;
  localparam logic [1:0] WB_SEL_PORT = 2'b11;

  typedef enum logic {
    WB_IDLE  = 1'b0,
    WB_SWAP2 = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_data_mux.sv
// Result-source select for the writeback stage.
// Pure 4:1 width-preserving multiplexer keyed by wb_sel.
module wb_data_mux
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W
) (
  input  logic [1:0]        wb_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] immediate,
  input  logic [DATA_W-1:0] port_data,
  output logic [DATA_W-1:0] result
);

  // pick one of the four result buses
  always_comb begin
    result = alu_result;
    unique case (wb_sel)
      WB_SEL_ALU:  result = alu_result;
      WB_SEL_MEM:  result = mem_data;
      WB_SEL_IMM:  result = immediate;
      WB_SEL_PORT: result = port_data;
      default:     result = alu_result;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB register and register-file write-port driver.
// SWAP takes two cycles; WB_BYPASS_EN exports the write port as a bypass.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              flush,
  input  logic              in_wb_en,
  input  logic [1:0]        in_wb_sel,
  input  logic [ADDR_W-1:0] in_dst_addr,
  input  logic [ADDR_W-1:0] in_src_addr,
  input  logic              in_swap,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_immediate,
  input  logic [DATA_W-1:0] in_port_data,
  input  logic [DATA_W-1:0] in_swap_data,
  output logic              write_back,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              stall_req,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data
);

  wb_state_e         state;
  wb_state_e         state_n;
  logic              we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] data_n;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] src_n;
  logic [DATA_W-1:0] swd_q;
  logic [DATA_W-1:0] swd_n;
  logic [DATA_W-1:0] mux_data;
  logic              accept;

  wb_data_mux #(
    .DATA_W (DATA_W)
  ) u_mux (
    .wb_sel     (in_wb_sel),
    .alu_result (in_alu_result),
    .mem_data   (in_mem_data),
    .immediate  (in_immediate),
    .port_data  (in_port_data),
    .result     (mux_data)
  );

  assign accept    = in_valid & ~flush;
  assign stall_req = (state == WB_SWAP2);

  // next write-port values and state; SWAP2 ignores every input
  always_comb begin
    state_n = state;
    we_n    = 1'b0;
    addr_n  = write_addr;
    data_n  = write_data;
    src_n   = src_q;
    swd_n   = swd_q;
    unique case (state)
      WB_IDLE: begin
        if (accept) begin
          we_n   = in_wb_en;
          addr_n = in_dst_addr;
          data_n = mux_data;
          if (in_swap && in_wb_en) begin
            src_n   = in_src_addr;
            swd_n   = in_swap_data;
            state_n = WB_SWAP2;
          end
        end
      end
      WB_SWAP2: begin
        we_n    = 1'b1;
        addr_n  = src_q;
        data_n  = swd_q;
        state_n = WB_IDLE;
      end
      default: state_n = WB_IDLE;
    endcase
  end

  // state, pending swap operand and registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WB_IDLE;
      write_back <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      src_q      <= '0;
      swd_q      <= '0;
    end else begin
      state      <= state_n;
      write_back <= we_n;
      write_addr <= addr_n;
      write_data <= data_n;
      src_q      <= src_n;
      swd_q      <= swd_n;
    end
  end

`ifdef WB_BYPASS_EN
  assign fwd_valid = write_back;
  assign fwd_addr  = write_addr;
  assign fwd_data  = write_data;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

endmodule
